muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide controller owning the HI/LO register pair for the five-stage pipeline. It accepts one operation per issue from the EX stage and models the fixed latency of the multiplier/divider with a down-counter. It commits results to HI/LO at completion and raises a stall request so that ID holds any HI/LO-dependent instruction until the unit is free.

---
 rtl/muldiv_ctrl.sv | 125 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide controller owning the HI/LO pair; fixed latency modelled by a counter.
// Define MULDIV_DIV_EN to build DIV/DIVU support; otherwise ops 2/3 are reserved.
module muldiv_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_use_id,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;

  logic        is_mul, is_div;
  logic [63:0] prod_s, prod_u;
  logic [31:0] div_q, div_r;

  assign is_mul = (op == 3'd0) || (op == 3'd1);
  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

`ifdef MULDIV_DIV_EN
  assign is_div = (op == 3'd2) || (op == 3'd3);

  always_comb begin
    div_q = 32'hFFFF_FFFF;
    div_r = src_a;
    if (src_b == 32'd0) begin
      div_q = 32'hFFFF_FFFF;
      div_r = src_a;
    end else if (op == 3'd3) begin
      div_q = src_a / src_b;
      div_r = src_a % src_b;
    end else if ((src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF)) begin
      div_q = 32'h8000_0000;
      div_r = 32'd0;
    end else begin
      div_q = $unsigned($signed(src_a) / $signed(src_b));
      div_r = $unsigned($signed(src_a) % $signed(src_b));
    end
  end
`else
  assign is_div = 1'b0;
  assign div_q  = 32'd0;
  assign div_r  = 32'd0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_mul) begin
            res_hi_d = (op == 3'd0) ? prod_s[63:32] : prod_u[63:32];
            res_lo_d = (op == 3'd0) ? prod_s[31:0]  : prod_u[31:0];
            cnt_d    = 4'(MULT_CYCLES);
            state_d  = StRun;
          end else if (is_div) begin
            res_hi_d = div_r;
            res_lo_d = div_q;
            cnt_d    = 4'(DIV_CYCLES);
            state_d  = StRun;
          end else if (op == 3'd4) begin
            hi_d = src_a;
          end else if (op == 3'd5) begin
            lo_d = src_a;
          end
        end
      end
      StRun: begin
        // start is ignored here; upstream stall keeps new md ops out.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  assign busy  = (state_q == StRun);
  assign stall = md_use_id && (busy || (start && (is_mul || is_div)));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed table-driven bench for muldiv_ctrl plus hand sequences for mid-RUN start and reset abort.
module tb_muldiv_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_use_id;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .md_use_id(md_use_id),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int unsigned cyc;
  } vec_t;

  vec_t vec[$];
  int n_total;
  int n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    int nb;
    int stall_bad;
    logic [2:0] long_op;

    n_total   = 0;
    n_pass    = 0;
    reset     = 1'b0;
    start     = 1'b0;
    op        = 3'd0;
    src_a     = 32'd0;
    src_b     = 32'd0;
    md_use_id = 1'b1;

    vec.push_back('{3'd0, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 5});
    vec.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5});
    vec.push_back('{3'd4, 32'hDEAD_BEEF, 32'd0,        32'hDEAD_BEEF, 32'h0000_0001, 0});
    vec.push_back('{3'd5, 32'h1234_5678, 32'd9,        32'hDEAD_BEEF, 32'h1234_5678, 0});
    vec.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5});
    vec.push_back('{3'd1, 32'h8000_0000, 32'd2,        32'h0000_0001, 32'h0000_0000, 5});
    vec.push_back('{3'd6, 32'h1111_1111, 32'd3,        32'h0000_0001, 32'h0000_0000, 0});
    vec.push_back('{3'd7, 32'h2222_2222, 32'd4,        32'h0000_0001, 32'h0000_0000, 0});
`ifdef MULDIV_DIV_EN
    vec.push_back('{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
    vec.push_back('{3'd3, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, 10});
    vec.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10});
    vec.push_back('{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10});
    vec.push_back('{3'd3, 32'hFFFF_FFFF, 32'd10,       32'h0000_0005, 32'h1999_9999, 10});
    vec.push_back('{3'd2, 32'hFFFF_FFF8, 32'd0,        32'hFFFF_FFF8, 32'hFFFF_FFFF, 10});
    long_op = 3'd2;
`else
    vec.push_back('{3'd2, 32'd100,       32'd3,        32'h0000_0001, 32'h0000_0000, 0});
    vec.push_back('{3'd3, 32'd100,       32'd0,        32'h0000_0001, 32'h0000_0000, 0});
    long_op = 3'd0;
`endif

    // Reset state; md_use_id alone must not stall.
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vec[i]) begin
      @(negedge clk);
      md_use_id = 1'b1;
      start     = 1'b1;
      op        = vec[i].op;
      src_a     = vec[i].a;
      src_b     = vec[i].b;
      #1;
      check($sformatf("issue_stall[%0d]", i), {31'd0, stall}, {31'd0, vec[i].cyc != 0});
      @(posedge clk);
      #1;
      start     = 1'b0;
      md_use_id = 1'b0;
      nb = 0;
      while (busy && nb < 40) begin
        @(posedge clk);
        #1;
        nb++;
      end
      check($sformatf("busy_cycles[%0d]", i), nb, vec[i].cyc);
      check($sformatf("hi[%0d]", i), hi, vec[i].exp_hi);
      check($sformatf("lo[%0d]", i), lo, vec[i].exp_lo);
    end

    // Stall held through RUN; a start (MTHI) arriving mid-RUN is ignored.
    @(negedge clk);
    md_use_id = 1'b1;
    start     = 1'b1;
    op        = 3'd0;
    src_a     = 32'd3;
    src_b     = 32'd4;
    @(posedge clk);
    #1;
    op        = 3'd4;
    src_a     = 32'hAAAA_AAAA;
    nb        = 0;
    stall_bad = 0;
    while (busy && nb < 40) begin
      if (!stall) stall_bad++;
      @(posedge clk);
      #1;
      nb++;
      if (nb == 2) start = 1'b0;
    end
    check("midrun_busy_cycles", nb, 5);
    check("midrun_stall_low_cycles", stall_bad, 0);
    check("post_commit_stall", {31'd0, stall}, 32'd0);
    check("midrun_hi", hi, 32'd0);
    check("midrun_lo", lo, 32'd12);

    // Back-to-back: issue on the first cycle after busy drops.
    @(negedge clk);
    start = 1'b1;
    op    = 3'd1;
    src_a = 32'd6;
    src_b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    nb = 0;
    while (busy && nb < 40) begin
      @(posedge clk);
      #1;
      nb++;
    end
    check("b2b_lo", lo, 32'd42);

    // Reset in the middle of a long op aborts without commit.
    @(negedge clk);
    start = 1'b1;
    op    = 3'd4;
    src_a = 32'h0000_0055;
    @(negedge clk);
    op    = long_op;
    src_a = 32'd77;
    src_b = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("post_abort_busy", {31'd0, busy}, 32'd0);
    check("post_abort_hi", hi, 32'd0);
    check("post_abort_lo", lo, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
